// File: rtl/reg_scoreboard_pkg.sv
// Shared constants for the decode-stage register scoreboard: register-file geometry,
// file-select encoding and counter widths.
package reg_scoreboard_pkg;

    localparam int NREG_DEFAULT  = 32;
    localparam int IDX_W_DEFAULT = $clog2(NREG_DEFAULT);
    localparam int CNT_W_DEFAULT = 16;

    // pend_cnt must hold 0..2*NREG, i.e. 0..64 for two 32-entry files
    localparam int PCNT_W = 7;

    localparam logic FILE_INT = 1'b0;
    localparam logic FILE_FP  = 1'b1;

endpackage : reg_scoreboard_pkg

// File: rtl/reg_pending_bank.sv
// One register file's worth of pending-write bits, with a set port (issue), a clear port
// (writeback) and two read lookups for the decode source operands.
module reg_pending_bank
    import reg_scoreboard_pkg::*;
#(
    parameter int NREG     = NREG_DEFAULT,
    parameter bit TIE_ZERO = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set_en,
    input  logic [$clog2(NREG)-1:0]  set_idx,
    input  logic                     clr_en,
    input  logic [$clog2(NREG)-1:0]  clr_idx,
    input  logic [$clog2(NREG)-1:0]  rd0_idx,
    input  logic [$clog2(NREG)-1:0]  rd1_idx,
    output logic                     hit0,
    output logic                     hit1,
    output logic [NREG-1:0]          pend,
    output logic [NREG-1:0]          pend_next,
    output logic                     spurious
);

    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;
    logic            clr_is_zero;

    assign clr_is_zero = TIE_ZERO && (clr_idx == '0);

    // Clear first so a same-cycle set of the same bit wins
    always_comb begin
        pend_d = pend_q;
        if (clr_en) begin
            pend_d[clr_idx] = 1'b0;
        end
        if (set_en) begin
            pend_d[set_idx] = 1'b1;
        end
        if (TIE_ZERO) begin
            pend_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign hit0      = pend_q[rd0_idx];
    assign hit1      = pend_q[rd1_idx];
    assign pend      = pend_q;
    assign pend_next = pend_d;
    assign spurious  = clr_en && !pend_q[clr_idx] && !clr_is_zero;

endmodule : reg_pending_bank

// File: rtl/reg_scoreboard.sv
// Decode-stage scoreboard: tracks outstanding integer/FP register writes and stalls decode
// on RAW/WAW hazards until the matching writeback retires (no writeback bypass).
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NREG  = NREG_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [$clog2(NREG)-1:0]  id_rs1,
    input  logic [$clog2(NREG)-1:0]  id_rs2,
    input  logic                     id_rs1_fp,
    input  logic                     id_rs2_fp,
    input  logic                     id_rs1_used,
    input  logic                     id_rs2_used,
    input  logic [$clog2(NREG)-1:0]  id_rd,
    input  logic                     id_rd_fp,
    input  logic                     id_rd_we,
    input  logic                     flush,
    input  logic                     wb_int_we,
    input  logic                     wb_fp_we,
    input  logic [$clog2(NREG)-1:0]  wb_rd_addr,
    output logic                     stall,
    output logic                     issue,
    output logic [PCNT_W-1:0]        pend_cnt,
    output logic [CNT_W-1:0]         stall_cycles,
    output logic                     err_spurious_wb
);

    logic            int_hit1, int_hit2, fp_hit1, fp_hit2;
    logic [NREG-1:0] int_pend, int_next, fp_pend, fp_next;
    logic            int_spurious, fp_spurious;
    logic            raw1, raw2, waw, hazard, live;
    logic            set_int, set_fp;

    logic [PCNT_W-1:0] pend_cnt_q, pend_cnt_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic              err_q, err_d;

    // Integer bank ties bit 0 low so x0 can never be pending or hazard
    reg_pending_bank #(
        .NREG     (NREG),
        .TIE_ZERO (1'b1)
    ) u_int_bank (
        .clk       (clk),
        .rst       (rst),
        .set_en    (set_int),
        .set_idx   (id_rd),
        .clr_en    (wb_int_we),
        .clr_idx   (wb_rd_addr),
        .rd0_idx   (id_rs1),
        .rd1_idx   (id_rs2),
        .hit0      (int_hit1),
        .hit1      (int_hit2),
        .pend      (int_pend),
        .pend_next (int_next),
        .spurious  (int_spurious)
    );

    reg_pending_bank #(
        .NREG     (NREG),
        .TIE_ZERO (1'b0)
    ) u_fp_bank (
        .clk       (clk),
        .rst       (rst),
        .set_en    (set_fp),
        .set_idx   (id_rd),
        .clr_en    (wb_fp_we),
        .clr_idx   (wb_rd_addr),
        .rd0_idx   (id_rs1),
        .rd1_idx   (id_rs2),
        .hit0      (fp_hit1),
        .hit1      (fp_hit2),
        .pend      (fp_pend),
        .pend_next (fp_next),
        .spurious  (fp_spurious)
    );

    always_comb begin
        raw1   = id_rs1_used && ((id_rs1_fp == FILE_FP) ? fp_hit1 : int_hit1);
        raw2   = id_rs2_used && ((id_rs2_fp == FILE_FP) ? fp_hit2 : int_hit2);
        waw    = id_rd_we && ((id_rd_fp == FILE_FP) ? fp_pend[id_rd] : int_pend[id_rd]);
        hazard = raw1 || raw2 || waw;
        live   = id_valid && !flush;
    end

    assign stall = live && hazard;
    assign issue = live && !hazard;

    always_comb begin
        set_int = issue && id_rd_we && (id_rd_fp == FILE_INT) && (id_rd != '0);
        set_fp  = issue && id_rd_we && (id_rd_fp == FILE_FP);
    end

    // Count tracks the bits' next state so it moves on the same edge as they do
    always_comb begin
        pend_cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            pend_cnt_d = pend_cnt_d + PCNT_W'(int_next[i]) + PCNT_W'(fp_next[i]);
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
        err_d = err_q || int_spurious || fp_spurious;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_cnt_q     <= '0;
            stall_cycles_q <= '0;
            err_q          <= 1'b0;
        end else begin
            pend_cnt_q     <= pend_cnt_d;
            stall_cycles_q <= stall_cycles_d;
            err_q          <= err_d;
        end
    end

    assign pend_cnt        = pend_cnt_q;
    assign stall_cycles    = stall_cycles_q;
    assign err_spurious_wb = err_q;

endmodule : reg_scoreboard

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: a directed vector table, a reset-mid-stall
// sequence, and randomized traffic checked against a per-register reference model.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_rs1_fp, id_rs2_fp, id_rs1_used, id_rs2_used;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd_addr;
    logic        id_rd_fp, id_rd_we, flush, wb_int_we, wb_fp_we;
    logic        stall, issue, err_spurious_wb;
    logic [6:0]  pend_cnt;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       valid;
        logic [4:0] rs1;
        logic       rs1_fp, rs1_used;
        logic [4:0] rs2;
        logic       rs2_fp, rs2_used;
        logic [4:0] rd;
        logic       rd_fp, rd_we, fl, wb_int, wb_fp;
        logic [4:0] wb_addr;
        logic       exp_stall, exp_issue;
        int         exp_cnt;
        logic       exp_err;
        int         exp_cycles;
    } vec_t;

    vec_t vecs[$];

    // Reference model: one pending flag per (file, register)
    bit m_pend[2][32];
    int m_cycles;
    bit m_err;

    reg_scoreboard dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs1_fp       (id_rs1_fp),
        .id_rs2_fp       (id_rs2_fp),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .id_rd           (id_rd),
        .id_rd_fp        (id_rd_fp),
        .id_rd_we        (id_rd_we),
        .flush           (flush),
        .wb_int_we       (wb_int_we),
        .wb_fp_we        (wb_fp_we),
        .wb_rd_addr      (wb_rd_addr),
        .stall           (stall),
        .issue           (issue),
        .pend_cnt        (pend_cnt),
        .stall_cycles    (stall_cycles),
        .err_spurious_wb (err_spurious_wb)
    );

    always #5 clk = ~clk;

    // Modes: 0 = unused, 1 = integer file, 2 = FP file; wb mode bit0 = int, bit1 = fp
    task automatic addRow(input logic v, input int r1, input int m1, input int r2, input int m2,
                          input int rd, input int md, input logic fl, input int wbm, input int wba,
                          input logic es, input logic ei, input int ec, input logic ee, input int ecy);
        vec_t t;
        t.valid = v;
        t.rs1 = 5'(r1); t.rs1_used = (m1 != 0); t.rs1_fp = (m1 == 2);
        t.rs2 = 5'(r2); t.rs2_used = (m2 != 0); t.rs2_fp = (m2 == 2);
        t.rd = 5'(rd);  t.rd_we = (md != 0);    t.rd_fp = (md == 2);
        t.fl = fl;
        t.wb_int = wbm[0]; t.wb_fp = wbm[1]; t.wb_addr = 5'(wba);
        t.exp_stall = es; t.exp_issue = ei; t.exp_cnt = ec; t.exp_err = ee; t.exp_cycles = ecy;
        vecs.push_back(t);
    endtask

    task automatic applyStimulus(input vec_t t);
        id_valid    = t.valid;
        id_rs1      = t.rs1;  id_rs1_fp = t.rs1_fp; id_rs1_used = t.rs1_used;
        id_rs2      = t.rs2;  id_rs2_fp = t.rs2_fp; id_rs2_used = t.rs2_used;
        id_rd       = t.rd;   id_rd_fp  = t.rd_fp;  id_rd_we    = t.rd_we;
        flush       = t.fl;
        wb_int_we   = t.wb_int; wb_fp_we = t.wb_fp; wb_rd_addr = t.wb_addr;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic vec_t idleVec();
        vec_t t;
        t = '{default: '0};
        return t;
    endfunction

    function automatic int modelCount();
        int c = 0;
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < 32; r++)
                c += int'(m_pend[f][r]);
        return c;
    endfunction

    task automatic modelReset();
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < 32; r++)
                m_pend[f][r] = 1'b0;
        m_cycles = 0;
        m_err    = 1'b0;
    endtask

    task automatic doReset();
        applyStimulus(idleVec());
        rst = 1'b1;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One randomized cycle: drive, compare against the model, then advance the model
    task automatic randomCycle(input bit clean);
        vec_t t;
        bit   hz, e_stall, e_issue;
        int   f;
        int   cand[$];
        t = idleVec();
        t.valid    = ($urandom_range(0, 3) != 0);
        t.rs1      = 5'($urandom_range(0, 7)); t.rs1_fp = 1'($urandom); t.rs1_used = 1'($urandom);
        t.rs2      = 5'($urandom_range(0, 7)); t.rs2_fp = 1'($urandom); t.rs2_used = 1'($urandom);
        t.rd       = 5'($urandom_range(0, 7)); t.rd_fp  = 1'($urandom); t.rd_we    = 1'($urandom);
        t.fl       = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 2) == 0) begin
            f = int'($urandom_range(0, 1));
            if (clean) begin
                for (int r = 0; r < 32; r++)
                    if (m_pend[f][r]) cand.push_back(r);
                if (cand.size() > 0) begin
                    t.wb_addr = 5'(cand[$urandom_range(0, cand.size() - 1)]);
                    if (f == 0) t.wb_int = 1'b1; else t.wb_fp = 1'b1;
                end
            end else begin
                t.wb_addr = 5'($urandom_range(0, 7));
                t.wb_int  = (f == 0) || ($urandom_range(0, 3) == 0);
                t.wb_fp   = (f == 1) || ($urandom_range(0, 3) == 0);
            end
        end
        @(negedge clk);
        applyStimulus(t);
        #1;
        hz = (t.rs1_used && m_pend[t.rs1_fp][t.rs1]) || (t.rs2_used && m_pend[t.rs2_fp][t.rs2])
             || (t.rd_we && m_pend[t.rd_fp][t.rd]);
        e_stall = t.valid && !t.fl && hz;
        e_issue = t.valid && !t.fl && !hz;
        checkOutput("rnd_stall", int'(stall), int'(e_stall));
        checkOutput("rnd_issue", int'(issue), int'(e_issue));
        checkOutput("rnd_pend_cnt", int'(pend_cnt), modelCount());
        checkOutput("rnd_err", int'(err_spurious_wb), int'(m_err));
        checkOutput("rnd_stall_cycles", int'(stall_cycles), m_cycles);
        if (t.wb_int) begin
            if (!m_pend[0][t.wb_addr] && t.wb_addr != 0) m_err = 1'b1;
            m_pend[0][t.wb_addr] = 1'b0;
        end
        if (t.wb_fp) begin
            if (!m_pend[1][t.wb_addr]) m_err = 1'b1;
            m_pend[1][t.wb_addr] = 1'b0;
        end
        if (e_issue && t.rd_we && !(t.rd_fp == 1'b0 && t.rd == 0)) m_pend[t.rd_fp][t.rd] = 1'b1;
        if (e_stall && m_cycles != 65535) m_cycles++;
    endtask

    initial begin
        vec_t t;
        doReset();
        checkOutput("reset_pend_cnt", int'(pend_cnt), 0);
        checkOutput("reset_stall_cycles", int'(stall_cycles), 0);
        checkOutput("reset_err", int'(err_spurious_wb), 0);
        checkOutput("reset_stall_idle", int'(stall), 0);
        checkOutput("reset_issue_idle", int'(issue), 0);

        //     v   rs1 m1 rs2 m2 rd md fl wbm wba  stall issue cnt err cyc
        addRow(1,  5, 1,  6, 1, 7, 1, 0, 0, 0,   0, 1, 0, 0, 0);
        addRow(1,  7, 1,  0, 0, 8, 1, 0, 0, 0,   1, 0, 1, 0, 0);
        addRow(1,  7, 1,  0, 0, 8, 1, 0, 1, 7,   1, 0, 1, 0, 1);
        addRow(1,  7, 1,  0, 0, 8, 1, 0, 0, 0,   0, 1, 0, 0, 2);
        addRow(1,  0, 0,  0, 0, 3, 2, 0, 0, 0,   0, 1, 1, 0, 2);
        addRow(1,  3, 2,  0, 0, 0, 0, 0, 0, 0,   1, 0, 2, 0, 2);
        addRow(1,  3, 2,  0, 0, 0, 0, 0, 0, 0,   1, 0, 2, 0, 3);
        addRow(1,  0, 0,  3, 2, 0, 0, 0, 2, 3,   1, 0, 2, 0, 4);
        addRow(1,  0, 0,  3, 2, 0, 0, 0, 0, 0,   0, 1, 1, 0, 5);
        addRow(1,  8, 0,  0, 0, 3, 1, 0, 0, 0,   0, 1, 1, 0, 5);
        addRow(1,  3, 2,  0, 0, 0, 0, 0, 0, 0,   0, 1, 2, 0, 5);
        addRow(1,  0, 0,  0, 0, 3, 1, 0, 0, 0,   1, 0, 2, 0, 5);
        addRow(1,  0, 1,  0, 0, 0, 1, 0, 0, 0,   0, 1, 2, 0, 6);
        addRow(1,  0, 1,  0, 1, 0, 0, 0, 0, 0,   0, 1, 2, 0, 6);
        addRow(0,  0, 0,  0, 0, 0, 0, 0, 1, 0,   0, 0, 2, 0, 6);
        addRow(0,  0, 0,  0, 0, 0, 0, 0, 0, 0,   0, 0, 2, 0, 6);
        addRow(0,  0, 0,  0, 0, 0, 0, 0, 1, 9,   0, 0, 2, 0, 6);
        addRow(0,  0, 0,  0, 0, 0, 0, 0, 0, 0,   0, 0, 2, 1, 6);
        addRow(0,  0, 0,  0, 0, 0, 0, 0, 1, 8,   0, 0, 2, 1, 6);
        addRow(0,  0, 0,  0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 6);
        addRow(1,  0, 0,  0, 0, 3, 1, 1, 0, 0,   0, 0, 1, 1, 6);
        addRow(0,  0, 0,  0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 6);
        addRow(0,  0, 0,  0, 0, 0, 0, 0, 3, 3,   0, 0, 1, 1, 6);
        addRow(0,  0, 0,  0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 6);

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d_stall", i), int'(stall), int'(vecs[i].exp_stall));
            checkOutput($sformatf("vec%0d_issue", i), int'(issue), int'(vecs[i].exp_issue));
            checkOutput($sformatf("vec%0d_pend_cnt", i), int'(pend_cnt), vecs[i].exp_cnt);
            checkOutput($sformatf("vec%0d_err", i), int'(err_spurious_wb), int'(vecs[i].exp_err));
            checkOutput($sformatf("vec%0d_stall_cycles", i), int'(stall_cycles), vecs[i].exp_cycles);
        end

        // Reset asserted in the middle of a stall clears everything at once
        t = idleVec();
        t.valid = 1'b1; t.rd = 5'd5; t.rd_we = 1'b1;
        @(negedge clk);
        applyStimulus(t);
        #1;
        checkOutput("mid_producer_issue", int'(issue), 1);
        t = idleVec();
        t.valid = 1'b1; t.rs1 = 5'd5; t.rs1_used = 1'b1;
        @(negedge clk);
        applyStimulus(t);
        #1;
        checkOutput("mid_consumer_stall", int'(stall), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_stall", int'(stall), 0);
        checkOutput("mid_rst_issue", int'(issue), 1);
        checkOutput("mid_rst_pend_cnt", int'(pend_cnt), 0);
        checkOutput("mid_rst_stall_cycles", int'(stall_cycles), 0);
        checkOutput("mid_rst_err", int'(err_spurious_wb), 0);
        @(negedge clk);
        rst = 1'b0;
        t = idleVec();
        t.wb_int = 1'b1; t.wb_addr = 5'd5;
        applyStimulus(t);
        @(negedge clk);
        applyStimulus(idleVec());
        #1;
        checkOutput("post_rst_wb_err", int'(err_spurious_wb), 1);
        checkOutput("post_rst_pend_cnt", int'(pend_cnt), 0);

        // Random traffic: legal writebacks first, then unconstrained ones
        doReset();
        for (int n = 0; n < 300; n++) randomCycle(1'b1);
        for (int n = 0; n < 300; n++) randomCycle(1'b0);

        @(negedge clk);
        applyStimulus(idleVec());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_reg_scoreboard
